aes_128_decrypt: RTL and testbench

Iterative AES-128 inverse cipher (FIPS-197) that recovers plaintext from the 128-bit ciphertext produced by the encryption top. It sits on the receive side of the crypto datapath and accepts a {ciphertext, key} pair through a valid/ready handshake. It derives the round-10 key on the fly, runs ten inverse rounds while walking the key schedule backwards, and holds the plaintext until the consumer takes it. One block is in flight at a time.

---
 rtl/aes_pkg.sv | 91 +++++++++
 rtl/aes_inv_round.sv | 40 ++++
 rtl/aes_128_decrypt.sv | 128 ++++++++++++
 tb/tb_aes_128_decrypt.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants and helpers: S-boxes, GF(2^8) arithmetic,
// key-schedule word steps and the decrypt FSM state type.
package aes_pkg;

   typedef enum logic [1:0] {IDLE, KEXP, ROUND, DONE} dec_state_e;

   localparam logic [7:0] RCON_FIRST = 8'h01;
   localparam logic [7:0] RCON_LAST  = 8'h36;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // Multiplier is at most 14, so four shift-and-add steps cover it
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int unsigned i = 0; i < 4; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] inv_rcon(input logic [7:0] r);
      return (r == 8'h1b) ? 8'h80 : {1'b0, r[7:1]};
   endfunction

   function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
      return {SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]], SBOX[w[31:24]]};
   endfunction

   function automatic logic [127:0] key_expand_fwd(input logic [127:0] rk, input logic [7:0] rcon);
      logic [31:0] w0, w1, w2, w3;
      w0 = rk[127:96] ^ sub_rot_word(rk[31:0]) ^ {rcon, 24'h0};
      w1 = rk[95:64] ^ w0;
      w2 = rk[63:32] ^ w1;
      w3 = rk[31:0]  ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   function automatic logic [127:0] key_expand_back(input logic [127:0] rk, input logic [7:0] rcon);
      logic [31:0] w0, w1, w2, w3;
      w3 = rk[31:0]  ^ rk[63:32];
      w2 = rk[63:32] ^ rk[95:64];
      w1 = rk[95:64] ^ rk[127:96];
      w0 = rk[127:96] ^ sub_rot_word(w3) ^ {rcon, 24'h0};
      return {w0, w1, w2, w3};
   endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One AES inverse round, purely combinational: InvShiftRows, InvSubBytes,
// AddRoundKey, then InvMixColumns unless this is the final round.
module aes_inv_round
   import aes_pkg::*;
(
   input  logic [127:0] state,
   input  logic [127:0] round_key,
   input  logic         last,
   output logic [127:0] result
);

   logic [7:0] s [16];
   logic [7:0] k [16];
   logic [7:0] a [16];
   logic [7:0] m [16];

   always_comb begin
      for (int unsigned i = 0; i < 16; i++) begin
         s[i] = state[127-8*i -: 8];
         k[i] = round_key[127-8*i -: 8];
      end
      // Byte (r,c) after the inverse row shift comes from column (c-r) mod 4
      for (int unsigned c = 0; c < 4; c++) begin
         for (int unsigned r = 0; r < 4; r++) begin
            a[r+4*c] = INV_SBOX[s[r + 4*((c + 4 - r) % 4)]] ^ k[r+4*c];
         end
      end
      for (int unsigned c = 0; c < 4; c++) begin
         m[4*c]   = gmul(a[4*c], 4'd14) ^ gmul(a[4*c+1], 4'd11) ^ gmul(a[4*c+2], 4'd13) ^ gmul(a[4*c+3], 4'd9);
         m[4*c+1] = gmul(a[4*c], 4'd9)  ^ gmul(a[4*c+1], 4'd14) ^ gmul(a[4*c+2], 4'd11) ^ gmul(a[4*c+3], 4'd13);
         m[4*c+2] = gmul(a[4*c], 4'd13) ^ gmul(a[4*c+1], 4'd9)  ^ gmul(a[4*c+2], 4'd14) ^ gmul(a[4*c+3], 4'd11);
         m[4*c+3] = gmul(a[4*c], 4'd11) ^ gmul(a[4*c+1], 4'd13) ^ gmul(a[4*c+2], 4'd9)  ^ gmul(a[4*c+3], 4'd14);
      end
      result = '0;
      for (int unsigned i = 0; i < 16; i++) begin
         result[127-8*i -: 8] = last ? a[i] : m[i];
      end
   end

endmodule

// File: rtl/aes_128_decrypt.sv
// Iterative AES-128 inverse cipher: expands to the round-10 key in KEXP,
// then runs ten inverse rounds while stepping the key schedule backwards.
module aes_128_decrypt
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] ct,
   input  logic [127:0] key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] pt,
   output logic         busy
);

   dec_state_e   state_q;
   dec_state_e   state_d;
   logic         rst_done;
   logic [127:0] ct_q;
   logic [127:0] rk;
   logic [127:0] st;
   logic [127:0] pt_q;
   logic [127:0] rk_fwd;
   logic [127:0] rk_prev;
   logic [127:0] round_out;
   logic [7:0]   rcon;
   logic [3:0]   cnt;
   logic         step_last;
   logic         accept;

   assign step_last = (cnt == 4'd9);
   assign rk_fwd    = key_expand_fwd(rk, rcon);
   assign rk_prev   = key_expand_back(rk, rcon);
   assign accept    = in_valid & in_ready;
   assign pt        = pt_q;

   aes_inv_round u_round (
      .state     (st),
      .round_key (rk_prev),
      .last      (step_last),
      .result    (round_out)
   );

   // Keeps in_ready low until the first clock edge after reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_done <= 1'b0;
      else        rst_done <= 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = rst_done;
            if (in_valid && rst_done) state_d = KEXP;
         end
         KEXP: begin
            busy = 1'b1;
            if (step_last) state_d = ROUND;
         end
         ROUND: begin
            busy = 1'b1;
            if (step_last) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ct_q <= '0;
         rk   <= '0;
         st   <= '0;
         pt_q <= '0;
         rcon <= RCON_FIRST;
         cnt  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  ct_q <= ct;
                  rk   <= key;
                  rcon <= RCON_FIRST;
                  cnt  <= '0;
               end
            end
            KEXP: begin
               rk <= rk_fwd;
               if (step_last) begin
                  st   <= ct_q ^ rk_fwd;
                  rcon <= RCON_LAST;
                  cnt  <= '0;
               end else begin
                  rcon <= xtime(rcon);
                  cnt  <= cnt + 4'd1;
               end
            end
            ROUND: begin
               rk   <= rk_prev;
               st   <= round_out;
               rcon <= inv_rcon(rcon);
               if (step_last) begin
                  pt_q <= round_out;
                  cnt  <= '0;
               end else begin
                  cnt  <= cnt + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_128_decrypt.sv
// Scoreboard bench for aes_128_decrypt using FIPS-197 directed vectors.
module tb_aes_128_decrypt;

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] ct;
   logic [127:0] key;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] pt;
   logic         busy;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int acc_edge = 0;
   bit have_acc = 0;
   bit ov_prev  = 0;
   logic [127:0] exp_q [$];

   aes_128_decrypt dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ct        (ct),
      .key       (key),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .pt        (pt),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: sampled on the falling edge, describing the upcoming rising edge
   always @(negedge clk) begin
      if (!rst_n) begin
         have_acc = 0;
         ov_prev  = 0;
      end else begin
         if (in_valid && in_ready) begin
            if (have_acc) check("accept_gap_ge21", 128'((cyc + 1 - acc_edge) >= 21), 128'd1);
            acc_edge = cyc + 1;
            have_acc = 1;
         end
         if (out_valid && !ov_prev) check("latency", 128'(cyc - acc_edge), 128'd20);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("unexpected_out", 128'(exp_q.size()), 128'd1);
            else check("pt", pt, exp_q.pop_front());
         end
         ov_prev = out_valid;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!in_ready && n < 100) begin
         tick();
         n++;
      end
      check("accept_timeout", 128'(in_ready), 128'd1);
   endtask

   task automatic send(input logic [127:0] c, input logic [127:0] k, input logic [127:0] e);
      in_valid = 1'b1;
      ct       = c;
      key      = k;
      exp_q.push_back(e);
      wait_ready();
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_out();
      int n = 0;
      while (!out_valid && n < 200) begin
         tick();
         n++;
      end
      check("out_timeout", 128'(out_valid), 128'd1);
      if (out_ready) tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ct = '0; key = '0;
      #1;
      check("rst_in_ready", 128'(in_ready), 128'd0);
      check("rst_out_valid", 128'(out_valid), 128'd0);
      check("rst_busy", 128'(busy), 128'd0);
      check("rst_pt", pt, '0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("in_ready_after_rst", 128'(in_ready), 128'd1);

      // FIPS-197 C.1 and B
      send(C1_CT, C1_KEY, C1_PT);
      wait_out();
      send(B_CT, B_KEY, B_PT);
      wait_out();

      // Backpressure with an ignored in_valid pulse
      out_ready = 1'b0;
      send(C1_CT, C1_KEY, C1_PT);
      wait_out();
      for (int i = 0; i < 15; i++) begin
         check("bp_out_valid", 128'(out_valid), 128'd1);
         check("bp_pt_stable", pt, C1_PT);
         check("bp_in_ready", 128'(in_ready), 128'd0);
         if (i == 5) begin
            in_valid = 1'b1; ct = B_CT; key = B_KEY;
         end else begin
            in_valid = 1'b0;
         end
         tick();
      end
      out_ready = 1'b1;
      tick();
      check("bp_release_in_ready", 128'(in_ready), 128'd1);
      check("bp_release_out_valid", 128'(out_valid), 128'd0);

      // Back-to-back with in_valid held high
      exp_q.push_back(C1_PT);
      exp_q.push_back(B_PT);
      in_valid = 1'b1; ct = C1_CT; key = C1_KEY;
      wait_ready();
      tick();
      ct = B_CT; key = B_KEY;
      wait_ready();
      tick();
      in_valid = 1'b0;
      wait_out();

      // Reset at E+15, during ROUND
      send(C1_CT, C1_KEY, C1_PT);
      repeat (14) @(posedge clk);
      #1;
      check("busy_before_abort", 128'(busy), 128'd1);
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("abort_out_valid", 128'(out_valid), 128'd0);
      check("abort_busy", 128'(busy), 128'd0);
      check("abort_pt", pt, '0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      tick();
      send(C1_CT, C1_KEY, C1_PT);
      wait_out();

      // Inputs altered at E+3 must not affect the result
      send(B_CT, B_KEY, B_PT);
      repeat (2) @(posedge clk);
      #1;
      ct  = ~B_CT;
      key = ~B_KEY;
      wait_out();

      repeat (3) tick();
      check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
